simon_playback: RTL and testbench

- Output-side counterpart to the button debouncer. The debouncer turns noisy buttons into clean press/release events; this block turns a stored colour sequence into timed LED flashes and tone enables.
- The game controller issues `start`, and the block plays colours 0..length-1 from the sequence memory, one step at a time.
- It signals `done` when playback finishes and sits between the sequence RAM and the LED/tone drivers.

---
 rtl/simon_playback_pkg.sv | 22 ++
 rtl/simon_playback_if.sv | 27 ++
 rtl/simon_playback_countdown_timer.sv | 35 +++
 rtl/simon_playback.sv | 167 ++++++++++++++++
 tb/tb_simon_playback.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/simon_playback_pkg.sv
// Shared constants and colour helpers for the Simon game datapath.
package simon_playback_pkg;

  // Clock cycles per millisecond at the board clock rate.
  localparam int MILLI_SECOND = 100000;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    RED    = 2'd1,
    YELLOW = 2'd2,
    BLUE   = 2'd3
  } colour_e;

  // Colour code to one-hot LED vector (bit0 green, bit1 red, bit2 yellow, bit3 blue).
  // The button input decoder uses the same mapping in reverse.
  function automatic logic [3:0] colour_onehot(input logic [1:0] colour);
    logic [3:0] led;
    led = 4'b0001 << colour;
    return led;
  endfunction

endpackage

// File: rtl/simon_playback_if.sv
// Playback bundle: game controller requests, sequence RAM port, LED/tone drive.
interface simon_playback_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic              abort;
  logic [ADDR_W:0]   length;
  logic [ADDR_W-1:0] seq_addr;
  logic [1:0]        seq_data;
  logic [3:0]        led;
  logic              tone_en;
  logic [1:0]        tone_sel;
  logic              busy;
  logic              done;

  // Game controller and sequence RAM side.
  modport master (
    output start, abort, length, seq_data,
    input  seq_addr, led, tone_en, tone_sel, busy, done
  );

  // Playback engine side.
  modport slave (
    input  start, abort, length, seq_data,
    output seq_addr, led, tone_en, tone_sel, busy, done
  );
endinterface

// File: rtl/simon_playback_countdown_timer.sv
// Loadable down-counter that parks at zero; also used by the debouncer and game timeout.
module simon_playback_countdown_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_value_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load takes priority; otherwise count down and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/simon_playback.sv
// Plays a stored colour sequence as timed LED flashes with matching tone enables.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | seq_addr holds idx, RAM is reading
// LOAD  | seq_data valid, latch colour and light LED
// ON    | LED/tone lit, on-timer running
// OFF   | dark gap, off-timer running
// FIN   | one-cycle done pulse
module simon_playback #(
  parameter int MILLI_SECOND = simon_playback_pkg::MILLI_SECOND,
  parameter int ON_MS        = 400,
  parameter int OFF_MS       = 200,
  parameter int ADDR_W       = 5
) (
  input logic            clk,
  input logic            reset,
  simon_playback_if.slave pb
);
  import simon_playback_pkg::*;

  localparam int ON_CYC  = ON_MS * MILLI_SECOND;
  localparam int OFF_CYC = OFF_MS * MILLI_SECOND;
  localparam int CYC_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int TMR_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

  localparam logic [TMR_W-1:0]  ON_VAL  = TMR_W'(ON_CYC - 1);
  localparam logic [TMR_W-1:0]  OFF_VAL = TMR_W'(OFF_CYC - 1);
  localparam logic [ADDR_W:0]   LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_ON, S_OFF, S_FIN
  } state_e;

  state_e            state_q, state_d;
  // idx and length carry one extra bit so a full 2**ADDR_W sequence compares without wrapping.
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   idx_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        led_q, led_d;
  logic              tone_en_q, tone_en_d;
  logic [1:0]        tone_sel_q, tone_sel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_value;
  logic              tmr_zero;

  assign idx_inc = idx_q + LEN_ONE;

  simon_playback_countdown_timer #(.W(TMR_W)) u_timer (
    .clk          (clk),
    .reset        (reset),
    .load_i       (tmr_load),
    .load_value_i (tmr_value),
    .zero_o       (tmr_zero)
  );

  // Next-state and registered-output logic; abort from any active state wins.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    addr_d     = addr_q;
    led_d      = led_q;
    tone_en_d  = tone_en_q;
    tone_sel_d = tone_sel_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_value  = '0;

    if (pb.abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      led_d     = '0;
      tone_en_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pb.start && !pb.abort) begin
            busy_d = 1'b1;
            if (pb.length == '0) begin
              state_d = S_FIN;
              done_d  = 1'b1;
            end else begin
              len_d   = pb.length;
              idx_d   = '0;
              addr_d  = '0;
              state_d = S_FETCH;
            end
          end
        end
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          led_d      = colour_onehot(pb.seq_data);
          tone_en_d  = 1'b1;
          tone_sel_d = pb.seq_data;
          tmr_load   = 1'b1;
          tmr_value  = ON_VAL;
          state_d    = S_ON;
        end
        S_ON: begin
          if (tmr_zero) begin
            led_d     = '0;
            tone_en_d = 1'b0;
            tmr_load  = 1'b1;
            tmr_value = OFF_VAL;
            state_d   = S_OFF;
          end
        end
        S_OFF: begin
          if (tmr_zero) begin
            if (idx_q == (len_q - LEN_ONE)) begin
              state_d = S_FIN;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_inc;
              addr_d  = idx_inc[ADDR_W-1:0];
              state_d = S_FETCH;
            end
          end
        end
        S_FIN: begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      led_q      <= '0;
      tone_en_q  <= 1'b0;
      tone_sel_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      led_q      <= led_d;
      tone_en_q  <= tone_en_d;
      tone_sel_q <= tone_sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign pb.seq_addr = addr_q;
  assign pb.led      = led_q;
  assign pb.tone_en  = tone_en_q;
  assign pb.tone_sel = tone_sel_q;
  assign pb.busy     = busy_q;
  assign pb.done     = done_q;

endmodule

// File: tb/tb_simon_playback.sv
// Directed bench for simon_playback with short timing (ON_CYC=30, OFF_CYC=20).
module tb_simon_playback;

  localparam int AW = 5;

  logic clk;
  logic reset;
  logic [1:0] mem [32];

  simon_playback_if #(.ADDR_W(AW)) ifc ();

  simon_playback #(
    .MILLI_SECOND (10),
    .ON_MS        (3),
    .OFF_MS       (2),
    .ADDR_W       (AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pb    (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read sequence RAM.
  always @(posedge clk) ifc.seq_data <= mem[ifc.seq_addr];

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] step_led   [40];
  logic [4:0] step_addr  [40];
  int         step_start [40];
  int         step_len   [40];
  int n_steps, n_done, done_cyc, busy_cyc, end_cyc, tone_bad, timeout;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_onehot(input logic [1:0] c);
    case (c)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0010;
      2'd2:    return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  // Pulse start for one cycle; returns just after the accepting edge (cycle 1).
  task automatic launch(input logic [AW:0] len);
    ifc.start  = 1'b1;
    ifc.length = len;
    tick();
    ifc.start  = 1'b0;
  endtask

  // Observe one playback from cycle 1 until busy and done are both low.
  task automatic watch(input int budget, input int start_at, input logic [AW:0] start_len,
                       input int abort_at);
    int c;
    logic [3:0] prev;
    n_steps = 0; n_done = 0; done_cyc = -1; busy_cyc = 0; end_cyc = -1;
    tone_bad = 0; timeout = 1; prev = '0; c = 1;
    while (c < budget) begin
      if (ifc.led != 4'b0 && prev == 4'b0 && n_steps < 40) begin
        step_led[n_steps]   = ifc.led;
        step_addr[n_steps]  = ifc.seq_addr;
        step_start[n_steps] = c;
        step_len[n_steps]   = 0;
        n_steps++;
      end
      if (ifc.led != 4'b0 && n_steps > 0) step_len[n_steps-1]++;
      if (ifc.tone_en !== (ifc.led != 4'b0)) tone_bad++;
      if (ifc.done) begin n_done++; done_cyc = c; end
      if (ifc.busy) busy_cyc++;
      prev = ifc.led;
      if (!ifc.busy && !ifc.done) begin
        timeout = 0;
        end_cyc = c;
        break;
      end
      if (c == start_at) begin ifc.start = 1'b1; ifc.length = start_len; end
      if (c == abort_at) ifc.abort = 1'b1;
      tick();
      ifc.start = 1'b0;
      ifc.abort = 1'b0;
      c++;
    end
  endtask

  initial begin
    int bad;
    reset = 1'b1;
    ifc.start = 1'b0; ifc.abort = 1'b0; ifc.length = '0;
    for (int k = 0; k < 32; k++) mem[k] = 2'd0;
    repeat (3) tick();
    check("rst_led", ifc.led, 4'b0);
    check("rst_tone_en", ifc.tone_en, 1'b0);
    check("rst_tone_sel", ifc.tone_sel, 2'd0);
    check("rst_busy", ifc.busy, 1'b0);
    check("rst_done", ifc.done, 1'b0);
    check("rst_seq_addr", ifc.seq_addr, 5'd0);
    reset = 1'b0;
    tick();

    // Single step, colour yellow.
    mem[0] = 2'd2;
    launch(6'd1);
    check("s1_busy_c1", ifc.busy, 1'b1);
    check("s1_led_c1", ifc.led, 4'b0);
    tick();
    check("s1_led_c2", ifc.led, 4'b0);
    tick();
    check("s1_led_c3", ifc.led, 4'b0100);
    check("s1_tone_en_c3", ifc.tone_en, 1'b1);
    check("s1_tone_sel_c3", ifc.tone_sel, 2'd2);
    bad = 0;
    begin
      int on;
      on = 0;
      while (ifc.led != 4'b0 && on < 200) begin
        if (ifc.led !== 4'b0100 || ifc.tone_en !== 1'b1) bad++;
        on++;
        tick();
      end
      check("s1_on_cycles", on, 30);
    end
    check("s1_on_stable", bad, 0);
    check("s1_tone_off", ifc.tone_en, 1'b0);
    begin
      int dark;
      dark = 0;
      while (!ifc.done && dark < 200) begin
        if (ifc.led != 4'b0) bad++;
        dark++;
        tick();
      end
      check("s1_dark_cycles", dark, 20);
    end
    check("s1_done", ifc.done, 1'b1);
    check("s1_busy_fin", ifc.busy, 1'b1);
    tick();
    check("s1_done_fall", ifc.done, 1'b0);
    check("s1_busy_fall", ifc.busy, 1'b0);
    tick();

    // Three steps; length input changed after start has no effect.
    mem[0] = 2'd0; mem[1] = 2'd3; mem[2] = 2'd1;
    launch(6'd3);
    ifc.length = 6'd1;
    watch(400, -1, '0, -1);
    check("s3_timeout", timeout, 0);
    check("s3_steps", n_steps, 3);
    check("s3_led0", step_led[0], 4'b0001);
    check("s3_led1", step_led[1], 4'b1000);
    check("s3_led2", step_led[2], 4'b0010);
    check("s3_start0", step_start[0], 3);
    check("s3_start1", step_start[1], 55);
    check("s3_start2", step_start[2], 107);
    check("s3_len2", step_len[2], 30);
    check("s3_addr1", step_addr[1], 5'd1);
    check("s3_addr2", step_addr[2], 5'd2);
    check("s3_done_count", n_done, 1);
    check("s3_done_cyc", done_cyc, 157);
    check("s3_tone_track", tone_bad, 0);
    tick();

    // Zero length: immediate done, no LED.
    launch(6'd0);
    watch(20, -1, '0, -1);
    check("z_timeout", timeout, 0);
    check("z_steps", n_steps, 0);
    check("z_done_cyc", done_cyc, 1);
    check("z_busy_cyc", busy_cyc, 1);
    check("z_end_cyc", end_cyc, 2);
    tick();

    // Start while busy is ignored.
    mem[0] = 2'd1; mem[1] = 2'd2;
    launch(6'd2);
    watch(400, 20, 6'd5, -1);
    check("sb_timeout", timeout, 0);
    check("sb_steps", n_steps, 2);
    check("sb_led1", step_led[1], 4'b0100);
    check("sb_done_cyc", done_cyc, 105);
    check("sb_done_count", n_done, 1);
    tick();
    check("sb_idle_after", ifc.busy, 1'b0);

    // Abort mid-ON together with a start request.
    mem[0] = 2'd3;
    launch(6'd3);
    watch(400, 12, 6'd2, 12);
    check("ab_timeout", timeout, 0);
    check("ab_end_cyc", end_cyc, 13);
    check("ab_on_len", step_len[0], 10);
    check("ab_no_done", n_done, 0);
    check("ab_led", ifc.led, 4'b0);
    check("ab_tone_en", ifc.tone_en, 1'b0);
    tick();
    check("ab_stay_idle", ifc.busy, 1'b0);
    launch(6'd1);
    watch(400, -1, '0, -1);
    check("ab_re_steps", n_steps, 1);
    check("ab_re_addr", step_addr[0], 5'd0);
    check("ab_re_led", step_led[0], 4'b1000);
    check("ab_re_done_cyc", done_cyc, 53);
    tick();

    // Reset during OFF of step 1; start held during reset is not accepted.
    mem[0] = 2'd0; mem[1] = 2'd3; mem[2] = 2'd1;
    launch(6'd3);
    repeat (89) tick();
    check("rm_in_off_led", ifc.led, 4'b0);
    check("rm_in_off_sel", ifc.tone_sel, 2'd3);
    reset = 1'b1;
    ifc.start = 1'b1; ifc.length = 6'd2;
    tick();
    check("rm_busy", ifc.busy, 1'b0);
    check("rm_tone_sel", ifc.tone_sel, 2'd0);
    check("rm_seq_addr", ifc.seq_addr, 5'd0);
    check("rm_done", ifc.done, 1'b0);
    tick();
    check("rm_held_busy", ifc.busy, 1'b0);
    reset = 1'b0;
    ifc.start = 1'b0;
    tick();
    check("rm_post_busy", ifc.busy, 1'b0);
    launch(6'd1);
    watch(400, -1, '0, -1);
    check("rm_re_led", step_led[0], 4'b0001);
    check("rm_re_done_cyc", done_cyc, 53);
    tick();

    // Full-length sequence covers every address without wrapping.
    for (int k = 0; k < 32; k++) mem[k] = 2'((k * 3 + 1) % 4);
    launch(6'd32);
    watch(2000, -1, '0, -1);
    check("full_timeout", timeout, 0);
    check("full_steps", n_steps, 32);
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      if (step_led[k] !== exp_onehot(mem[k]) || step_addr[k] !== 5'(k) ||
          step_len[k] != 30 || step_start[k] != 3 + 52 * k) bad++;
    end
    check("full_step_content", bad, 0);
    check("full_done_cyc", done_cyc, 1665);
    check("full_done_count", n_done, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
